track_decoder: RTL
==================

# track_decoder

Conditions the three raw line-tracker IR sensor inputs and produces the 3-bit steering mode consumed by the motor block's mode input, plus a stop request. Each sensor is synchronised and debounced. A small FSM remembers which side the line was last seen on, steers toward that side for a bounded time when the line is lost, and halts the car if the line is not found. Sits between the sensor pins (JB2–JB4) and the motor block in the top level.

## Interface
- SYNC_STAGES, 2, flip-flop stages per sensor synchroniser (≥2)
- STABLE_CYCLES, 100000, consecutive cycles a new synced level must hold before it is accepted (1 ms at 100 MHz; ≥2)
- LOST_TIMEOUT, 50000000, maximum cycles spent in recovery before halting (0.5 s; ≥2)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- left_signal  input  1  raw left IR sensor, asynchronous
- mid_signal  input  1  raw middle IR sensor, asynchronous
- right_signal  input  1  raw right IR sensor, asynchronous
- mode  output  3  {left, mid, right} steering pattern to motor block, registered
- stop_req  output  1  high while halted; top level ORs it into the motor stop path
- fsm_state  output  2  current FSM state encoding, for LEDs

## Operation
- Filter, per sensor: a SYNC_STAGES flip-flop chain produces sync; filt resets to 0.
  - A counter runs while sync != filt and clears when sync == filt.
  - When the counter reaches STABLE_CYCLES-1 with sync still != filt, filt <= sync and the counter clears.
  - A glitch shorter than STABLE_CYCLES cycles never reaches filt.
- Pattern P = {filt_l, filt_m, filt_r}.
- last_side register, reset LEFT:
  - Updated in TRACK only.
  - P ∈ {100, 110} sets it to LEFT.
  - P ∈ {001, 011} sets it to RIGHT.
  - 010, 111 and 101 leave it unchanged.
- FSM states: HALT=00, TRACK=01, RECOVER_L=10, RECOVER_R=11. Reset state is HALT.
  - HALT: mode=000, stop_req=1. P != 000 → TRACK.
  - TRACK: mode=P, stop_req=0. P == 000 → RECOVER_L if last_side=LEFT, else RECOVER_R. The timeout counter clears on entry.
  - RECOVER_L: mode=100. RECOVER_R: mode=001. stop_req=0 in both.
    - The timeout counter increments every cycle.
    - P != 000 → TRACK.
    - Otherwise, counter == LOST_TIMEOUT-1 → HALT.
- Simultaneous events:
  - In the timeout cycle, P != 000 takes priority, and the FSM goes to TRACK.
  - rst overrides everything. It clears all sync, filt, counters and last_side, and forces HALT, even mid-recovery.
- Outputs are registered from the next-state decode, so mode and stop_req change on the same edge the state does.

## Timing
- Reset values:
  - mode=000, stop_req=1, fsm_state=00.
  - All synchronisers, filt, counters and last_side are 0, with last_side=LEFT.
- Input edge to filt change: SYNC_STAGES + STABLE_CYCLES cycles, given a level held steady throughout.
- filt change to mode/state update: 1 cycle.
- Total sensor-to-mode latency: SYNC_STAGES + STABLE_CYCLES + 1 cycles.
- Recovery duration: the FSM returns to HALT exactly LOST_TIMEOUT cycles after entering RECOVER_x, if P stays 000.
- Counter widths are $clog2 of the respective parameter. Counters never wrap: each clears or terminates at its limit.

## Configuration
- TRACK_RECOVER_EN defined:
  - Recovery states are present, as described above.
- TRACK_RECOVER_EN undefined:
  - RECOVER_L, RECOVER_R, the timeout counter and last_side are removed.
  - TRACK goes directly to HALT when P == 000.
  - fsm_state encodings 10 and 11 never appear.
  - All other behaviour is identical.

## Structure
- Package track_pkg holds:
  - the state enum (HALT, TRACK, RECOVER_L, RECOVER_R) and the side enum (LEFT, RIGHT);
  - mode constants MODE_STOP=000, MODE_LEFT=100, MODE_STRAIGHT=010, MODE_RIGHT=001.
- Sub-module sensor_filter (synchroniser + stability counter, parameters SYNC_STAGES and STABLE_CYCLES) is instantiated three times.
- The FSM lives in track_decoder.

## Test plan
All tests use SYNC_STAGES=2, STABLE_CYCLES=4, LOST_TIMEOUT=20.

1. Reset, then hold inputs 010 → mode stays 000 with stop_req=1 until cycle 7 after the input edge. mode becomes 010 and stop_req 0 at cycle 7 (2+4+1).
2. In TRACK with 010, pulse left_signal high for 3 cycles → mode unchanged, filt_l stays 0.
3. In TRACK, go 010 → 110 → 000, each held 10 cycles → mode 110, then 100 (RECOVER_L, fsm_state=10). mode holds 100 while P=000.
4. Recovery from the right: 011 then 000, held for 30 cycles → RECOVER_R (mode 001) for exactly 20 cycles, then HALT with mode=000 and stop_req=1.
5. Simultaneous events: in RECOVER_R, make P become 001 on the same cycle the counter hits 19 → next state TRACK, mode=001, stop_req=0.
6. Assert rst for 1 cycle mid-RECOVER_L → next cycle mode=000, stop_req=1, fsm_state=00, last_side=LEFT.
7. Build without TRACK_RECOVER_EN: 010 → 000 → HALT one cycle after P becomes 000, with no RECOVER state.

Source files
------------

// File: rtl/track_pkg.sv
// Shared types and constants for the line-tracker sensor decoder.
package track_pkg;

  typedef enum logic [1:0] {
    HALT      = 2'b00,
    TRACK     = 2'b01,
    RECOVER_L = 2'b10,
    RECOVER_R = 2'b11
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam logic [2:0] MODE_STOP     = 3'b000;
  localparam logic [2:0] MODE_LEFT     = 3'b100;
  localparam logic [2:0] MODE_STRAIGHT = 3'b010;
  localparam logic [2:0] MODE_RIGHT    = 3'b001;

endpackage

// File: rtl/track_decoder_if.sv
// Sensor pins in, steering mode / stop request / state out.
interface track_decoder_if;
  logic       left_signal;
  logic       mid_signal;
  logic       right_signal;
  logic [2:0] mode;
  logic       stop_req;
  logic [1:0] fsm_state;

  modport master (
    output left_signal, mid_signal, right_signal,
    input  mode, stop_req, fsm_state
  );

  modport slave (
    input  left_signal, mid_signal, right_signal,
    output mode, stop_req, fsm_state
  );
endinterface

// File: rtl/track_decoder_sensor_filter.sv
// One IR sensor: synchroniser chain followed by a stability (debounce) counter.
module sensor_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);
  localparam int unsigned CW = $clog2(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_filt = r_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/track_decoder.sv
// Line-tracker decoder: three debounced sensors feed the steering FSM.
// Optional line-loss recovery states are built when TRACK_RECOVER_EN is defined.
module track_decoder
  import track_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 100000,
  parameter int unsigned LOST_TIMEOUT  = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  track_decoder_if.slave  bus
);
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || LOST_TIMEOUT < 2) begin : g_param_check
    $error("track_decoder: SYNC_STAGES, STABLE_CYCLES and LOST_TIMEOUT must be >= 2");
  end

  logic       w_filt_l;
  logic       w_filt_m;
  logic       w_filt_r;
  logic [2:0] w_p;

  sensor_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_filt_l (
    .clk(clk), .rst(rst), .i_raw(bus.left_signal), .o_filt(w_filt_l)
  );
  sensor_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_filt_m (
    .clk(clk), .rst(rst), .i_raw(bus.mid_signal), .o_filt(w_filt_m)
  );
  sensor_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_filt_r (
    .clk(clk), .rst(rst), .i_raw(bus.right_signal), .o_filt(w_filt_r)
  );

  assign w_p = {w_filt_l, w_filt_m, w_filt_r};

  state_t     r_state;
  logic [2:0] r_mode;
  logic       r_stop;

  assign bus.mode      = r_mode;
  assign bus.stop_req  = r_stop;
  assign bus.fsm_state = r_state;

`ifdef TRACK_RECOVER_EN
  localparam int unsigned TW = $clog2(LOST_TIMEOUT);

  logic [TW-1:0] r_tmo;
  side_t         r_last;

  // mode/stop_req are loaded alongside the next state so all outputs move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HALT;
      r_mode  <= MODE_STOP;
      r_stop  <= 1'b1;
      r_tmo   <= '0;
      r_last  <= LEFT;
    end else begin
      case (r_state)
        HALT: begin
          if (w_p != MODE_STOP) begin
            r_state <= TRACK;
            r_mode  <= w_p;
            r_stop  <= 1'b0;
          end
        end
        TRACK: begin
          if (w_p == 3'b100 || w_p == 3'b110) begin
            r_last <= LEFT;
          end else if (w_p == 3'b001 || w_p == 3'b011) begin
            r_last <= RIGHT;
          end
          if (w_p == MODE_STOP) begin
            r_tmo <= '0;
            if (r_last == LEFT) begin
              r_state <= RECOVER_L;
              r_mode  <= MODE_LEFT;
            end else begin
              r_state <= RECOVER_R;
              r_mode  <= MODE_RIGHT;
            end
          end else begin
            r_mode <= w_p;
          end
        end
        RECOVER_L, RECOVER_R: begin
          // Reacquiring the line wins over an expiring timeout.
          if (w_p != MODE_STOP) begin
            r_state <= TRACK;
            r_mode  <= w_p;
          end else if (r_tmo == TW'(LOST_TIMEOUT - 1)) begin
            r_state <= HALT;
            r_mode  <= MODE_STOP;
            r_stop  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HALT;
      r_mode  <= MODE_STOP;
      r_stop  <= 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          if (w_p != MODE_STOP) begin
            r_state <= TRACK;
            r_mode  <= w_p;
            r_stop  <= 1'b0;
          end
        end
        TRACK: begin
          if (w_p == MODE_STOP) begin
            r_state <= HALT;
            r_mode  <= MODE_STOP;
            r_stop  <= 1'b1;
          end else begin
            r_mode <= w_p;
          end
        end
        default: begin
          r_state <= HALT;
          r_mode  <= MODE_STOP;
          r_stop  <= 1'b1;
        end
      endcase
    end
  end
`endif
endmodule
